// File: rtl/approx_mul_pkg.sv
// Shared types and constants for the approximate multiplier.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package approx_mul_pkg;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'b00,
        MODE_TRUNC = 2'b01,
        MODE_ORC   = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Bias added to the truncated product: half the weight of the dropped columns.
    function automatic logic [63:0] comp_const(input int trunc, input int width);
        if (trunc <= 0 || trunc >= 2 * width) begin
            return '0;
        end
        return 64'd1 << (trunc - 1);
    endfunction

endpackage

// File: rtl/approx_mul_core.sv
// Combinational exact and approximate product of two unsigned operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
module approx_mul_core
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 4
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [1:0]         mode,
    output logic [2*WIDTH-1:0] p_approx,
    output logic [2*WIDTH-1:0] p_exact
);

    localparam int PW = 2 * WIDTH;
    localparam logic [PW-1:0] HI_MASK = {PW{1'b1}} << TRUNC;
    localparam logic [PW-1:0] COMP    = PW'(comp_const(TRUNC, WIDTH));

    logic [PW-1:0] p_hi;
    logic [PW-1:0] p_or;
    logic [PW-1:0] row;

    // Each row a[i]*b<<i is split: upper columns summed, lower columns OR-ed.
    always_comb begin
        p_hi = '0;
        p_or = '0;
        row  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row  = (PW'(b) << i) & {PW{a[i]}};
            p_hi = p_hi + (row & HI_MASK);
            p_or = p_or | (row & ~HI_MASK);
        end
    end

    always_comb begin
        p_exact = PW'(a) * PW'(b);
        case (mode_e'(mode))
            MODE_TRUNC: p_approx = p_hi + COMP;
            MODE_ORC:   p_approx = p_hi | p_or;
            default:    p_approx = p_exact;
        endcase
    end

endmodule

// File: rtl/approx_mul_pipe.sv
// Pipelined approximate multiplier with in-system error statistics.
// Latency: 2 cycles accept-to-output (S1 operands, S2 product).
// Backpressure: elastic valid/ready, full throughput, stages hold while stalled.
module approx_mul_pipe
    import approx_mul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TRUNC = 4,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [2*WIDTH-1:0]   out_err,
    input  logic                 stat_clr,
    output logic [CNT_W-1:0]     txn_cnt,
    output logic [CNT_W-1:0]     mis_cnt,
    output logic [2*WIDTH-1:0]   wce
);

    localparam int PW = 2 * WIDTH;

    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    mode_e            mode_q, mode_d;
    logic             s2_v_q, s2_v_d;
    logic [PW-1:0]    p_q, p_d, err_q, err_d;
    logic [CNT_W-1:0] txn_q, txn_d, mis_q, mis_d;
    logic [PW-1:0]    wce_q, wce_d;

    logic             adv2;
    logic             out_hs;
    logic [PW-1:0]    p_approx, p_exact, diff;

    assign adv2     = !s2_v_q || out_ready;
    assign in_ready = !s1_v_q || adv2;
    assign out_hs   = s2_v_q && out_ready;

    approx_mul_core #(
        .WIDTH (WIDTH),
        .TRUNC (TRUNC)
    ) u_core (
        .a        (a_q),
        .b        (b_q),
        .mode     (mode_q),
        .p_approx (p_approx),
        .p_exact  (p_exact)
    );

    assign diff = (p_exact >= p_approx) ? (p_exact - p_approx) : (p_approx - p_exact);

    always_comb begin
        s1_v_d = s1_v_q;
        a_d    = a_q;
        b_d    = b_q;
        mode_d = mode_q;
        s2_v_d = s2_v_q;
        p_d    = p_q;
        err_d  = err_q;
        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                a_d    = in_a;
                b_d    = in_b;
                mode_d = mode_e'(in_mode);
            end
        end
        if (adv2) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                p_d   = p_approx;
                err_d = diff;
            end
        end
    end

    // A clear coinciding with an output handshake drops that handshake.
    always_comb begin
        txn_d = txn_q;
        mis_d = mis_q;
        wce_d = wce_q;
        if (stat_clr) begin
            txn_d = '0;
            mis_d = '0;
            wce_d = '0;
        end else if (out_hs) begin
            if (txn_q != {CNT_W{1'b1}}) begin
                txn_d = txn_q + CNT_W'(1);
            end
            if (err_q != '0 && mis_q != {CNT_W{1'b1}}) begin
                mis_d = mis_q + CNT_W'(1);
            end
            if (err_q > wce_q) begin
                wce_d = err_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_EXACT;
            s2_v_q <= 1'b0;
            p_q    <= '0;
            err_q  <= '0;
            txn_q  <= '0;
            mis_q  <= '0;
            wce_q  <= '0;
        end else begin
            s1_v_q <= s1_v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            s2_v_q <= s2_v_d;
            p_q    <= p_d;
            err_q  <= err_d;
            txn_q  <= txn_d;
            mis_q  <= mis_d;
            wce_q  <= wce_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_p     = p_q;
    assign out_err   = err_q;
    assign txn_cnt   = txn_q;
    assign mis_cnt   = mis_q;
    assign wce       = wce_q;

endmodule
